alu_exec_sequencer: RTL and testbench

- Execute-stage controller that sits directly upstream of the registered ALU. It accepts one decoded instruction through a valid/ready handshake and reads source operands from the register file.
- It drives the ALU opcode, operands and one-cycle alu_enable, then captures alu_out and writes it back to the register file.
- Strictly one instruction in flight; a 4-state FSM sequences read, execute and writeback.

---
 rtl/alu_exec_sequencer_pkg.sv | 28 ++
 rtl/alu_exec_sequencer_sign_extender.sv | 12 +
 rtl/alu_exec_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_exec_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared constants for the ALU execute sequencer: default widths, ALU opcode
// encoding and the sequencer FSM state encoding.
package alu_exec_sequencer_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_OPCODE_SIZE   = 4;
  localparam int DEF_REG_ADDR_SIZE = 3;
  localparam int DEF_IMM_SIZE      = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_ANDI = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_EXEC = 2'd2;
  localparam state_t ST_WB   = 2'd3;

endpackage

// File: rtl/alu_exec_sequencer_sign_extender.sv
// Sign-extends an IN_WIDTH immediate to OUT_WIDTH by replicating its top bit.
module sign_extender #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  in_value,
  output logic [OUT_WIDTH-1:0] out_value
);

  assign out_value = {{(OUT_WIDTH-IN_WIDTH){in_value[IN_WIDTH-1]}}, in_value};

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: one instruction in flight, read -> ALU -> writeback.
//   state | meaning
//   IDLE  | ready for a new instruction; ALU operands hold their last values
//   READ  | register file read; ALU operands and alu_enable registered
//   EXEC  | alu_enable high, ALU samples at the end of this cycle
//   WB    | rf_we high, ALU result written to rd, retired_count bumps on exit
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int OPCODE_SIZE   = DEF_OPCODE_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int IMM_SIZE      = DEF_IMM_SIZE
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OPCODE_SIZE-1:0]   instr_opcode,
  input  logic [REG_ADDR_SIZE-1:0] instr_rd,
  input  logic [REG_ADDR_SIZE-1:0] instr_rs1,
  input  logic [REG_ADDR_SIZE-1:0] instr_rs2,
  input  logic [IMM_SIZE-1:0]      instr_imm,
  output logic [REG_ADDR_SIZE-1:0] rf_raddr1,
  output logic [REG_ADDR_SIZE-1:0] rf_raddr2,
  input  logic [WORD_SIZE-1:0]     rf_rdata1,
  input  logic [WORD_SIZE-1:0]     rf_rdata2,
  output logic [OPCODE_SIZE-1:0]   alu_opcode,
  output logic [WORD_SIZE-1:0]     alu_in1,
  output logic [WORD_SIZE-1:0]     alu_in2,
  output logic                     alu_enable,
  input  logic [WORD_SIZE-1:0]     alu_result,
  output logic                     rf_we,
  output logic [REG_ADDR_SIZE-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]     rf_wdata,
  output logic [15:0]              retired_count
);

  state_t                   state;
  logic [OPCODE_SIZE-1:0]   op_q;
  logic [REG_ADDR_SIZE-1:0] rd_q;
  logic [IMM_SIZE-1:0]      imm_q;
  logic [WORD_SIZE-1:0]     imm_ext;
  logic [WORD_SIZE-1:0]     operand2;

  sign_extender #(
    .IN_WIDTH  (IMM_SIZE),
    .OUT_WIDTH (WORD_SIZE)
  ) u_sign_extender (
    .in_value  (imm_q),
    .out_value (imm_ext)
  );

  always_comb begin
    operand2 = rf_rdata2;
    if ((op_q == OPCODE_SIZE'(OP_ADDI)) || (op_q == OPCODE_SIZE'(OP_ANDI))) begin
      operand2 = imm_ext;
    end else if (op_q == OPCODE_SIZE'(OP_NOT)) begin
      operand2 = '0;
    end
  end

  assign instr_ready = (state == ST_IDLE);

  // The registered ALU only presents its result during WB, so the write data
  // is passed straight through while rf_we is high and parked at zero otherwise.
  assign rf_wdata = rf_we ? alu_result : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      rf_raddr1     <= '0;
      rf_raddr2     <= '0;
      alu_opcode    <= '0;
      alu_in1       <= '0;
      alu_in2       <= '0;
      alu_enable    <= 1'b0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      retired_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q      <= instr_opcode;
            rd_q      <= instr_rd;
            imm_q     <= instr_imm;
            rf_raddr1 <= instr_rs1;
            rf_raddr2 <= instr_rs2;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          alu_opcode <= op_q;
          alu_in1    <= rf_rdata1;
          alu_in2    <= operand2;
          alu_enable <= 1'b1;
          state      <= ST_EXEC;
        end
        ST_EXEC: begin
          alu_enable <= 1'b0;
          rf_we      <= 1'b1;
          rf_waddr   <= rd_q;
          state      <= ST_WB;
        end
        ST_WB: begin
          rf_we         <= 1'b0;
          retired_count <= retired_count + 16'd1;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: register file and registered ALU around the DUT,
// directed vector table, reset/wrap sequences and randomized instructions.
module tb_alu_exec_sequencer;
  import alu_exec_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_opcode = '0;
  logic [2:0]  instr_rd = '0;
  logic [2:0]  instr_rs1 = '0;
  logic [2:0]  instr_rs2 = '0;
  logic [7:0]  instr_imm = '0;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1, alu_in2, alu_result;
  logic        alu_enable, rf_we;
  logic [15:0] retired_count;

  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] rf [8] = '{default: 16'h0000};
  int          cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  alu_exec_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_rd      (instr_rd),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .instr_imm     (instr_imm),
    .rf_raddr1     (rf_raddr1),
    .rf_raddr2     (rf_raddr2),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .alu_opcode    (alu_opcode),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_enable    (alu_enable),
    .alu_result    (alu_result),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .retired_count (retired_count)
  );

  // Environment: combinational-read register file and a registered ALU.
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always @(posedge clock) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  function automatic logic [15:0] alu_env(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      OP_ADD, OP_ADDI: return x + y;
      OP_SUB:          return x - y;
      OP_AND, OP_ANDI: return x & y;
      OP_OR:           return x | y;
      OP_XOR:          return x ^ y;
      OP_NOT:          return ~x;
      OP_SHL:          return x << y[3:0];
      OP_SHR:          return x >> y[3:0];
      default:         return 16'h0000;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) alu_result <= 16'h0000;
    else if (alu_enable) alu_result <= alu_env(alu_opcode, alu_in1, alu_in2);
  end

  // Reference model: architectural effect of one instruction on register values.
  function automatic logic [15:0] sext(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

  function automatic logic [15:0] ref_in2(input logic [3:0] op, input logic [15:0] b, input logic [7:0] imm);
    if (op == OP_ADDI || op == OP_ANDI) return sext(imm);
    if (op == OP_NOT) return 16'h0000;
    return b;
  endfunction

  function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [7:0] imm);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_ADDI: return a + sext(imm);
      OP_ANDI: return a & sext(imm);
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      default: return 16'h0000;
    endcase
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] imm;
    int         acc;
  } pend_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm;
    logic [15:0] v1, v2, exp_in2, exp_wdata;
  } vec_t;

  pend_t       pend[$];
  int          wb_cyc[$];
  int          wb_total = 0;
  logic [15:0] ref_rf [8] = '{default: 16'h0000};
  logic [15:0] exp_retired = 16'h0000;
  logic [15:0] last_in2 = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event/timeout, required none (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Samples on the falling edge; accepted instructions are retired in order
  // against ref_rf, which holds the architectural register values.
  task automatic monitor();
    pend_t       p;
    logic [15:0] e_res;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend.delete();
        exp_retired = 16'h0000;
        continue;
      end
      chk("retired_count", retired_count, exp_retired);
      chk("instr_ready", {15'd0, instr_ready}, {15'd0, pend.size() == 0});
      if (alu_enable || rf_we) chk("enable_overlap", {15'd0, alu_enable & rf_we}, 16'h0000);
      if (alu_enable) begin
        if (pend.size() == 0) fail("alu_enable_spurious");
        else begin
          p = pend[0];
          chk("alu_enable_cycle", 16'(cyc - p.acc), 16'd1);
          chk("alu_opcode", {12'd0, alu_opcode}, {12'd0, p.op});
          chk("alu_in1", alu_in1, ref_rf[p.rs1]);
          chk("alu_in2", alu_in2, ref_in2(p.op, ref_rf[p.rs2], p.imm));
        end
      end
      if (rf_we) begin
        if (pend.size() == 0) fail("rf_we_spurious");
        else begin
          p = pend.pop_front();
          e_res = ref_result(p.op, ref_rf[p.rs1], ref_rf[p.rs2], p.imm);
          chk("rf_we_cycle", 16'(cyc - p.acc), 16'd2);
          chk("rf_waddr", {13'd0, rf_waddr}, {13'd0, p.rd});
          chk("rf_wdata", rf_wdata, e_res);
          last_in2   = alu_in2;
          last_wdata = rf_wdata;
          ref_rf[p.rd] = e_res;
          exp_retired  = exp_retired + 16'd1;
          wb_cyc.push_back(cyc);
          wb_total++;
        end
      end
      if (pl_en) ref_rf[pl_addr] = pl_data;
      if (instr_valid && instr_ready) begin
        p.op = instr_opcode; p.rd = instr_rd; p.rs1 = instr_rs1;
        p.rs2 = instr_rs2; p.imm = instr_imm; p.acc = cyc + 1;
        pend.push_back(p);
      end
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input bit hold);
    int n = 0;
    instr_opcode = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin step(); n++; end
    if (!instr_ready) fail("accept_timeout");
    step();
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(instr_ready && pend.size() == 0) && n < 20) begin step(); n++; end
    if (!(instr_ready && pend.size() == 0)) fail("done_timeout");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_instr_ready"}, {15'd0, instr_ready}, 16'd1);
    chk({tag, "_alu_enable"}, {15'd0, alu_enable}, 16'd0);
    chk({tag, "_rf_we"}, {15'd0, rf_we}, 16'd0);
    chk({tag, "_alu_opcode"}, {12'd0, alu_opcode}, 16'd0);
    chk({tag, "_alu_in1"}, alu_in1, 16'd0);
    chk({tag, "_alu_in2"}, alu_in2, 16'd0);
    chk({tag, "_rf_raddr"}, {10'd0, rf_raddr1, rf_raddr2}, 16'd0);
    chk({tag, "_rf_waddr"}, {13'd0, rf_waddr}, 16'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 16'd0);
    chk({tag, "_retired"}, retired_count, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base_wb;
    logic [15:0] base_ret;
    bit          hold;

    vecs[0] = '{OP_ADD,  3'd3, 3'd1, 3'd2, 8'h00, 16'h0005, 16'h0007, 16'h0007, 16'h000C};
    vecs[1] = '{OP_ADDI, 3'd4, 3'd1, 3'd2, 8'hFE, 16'h0010, 16'h0000, 16'hFFFE, 16'h000E};
    vecs[2] = '{OP_NOT,  3'd5, 3'd1, 3'd2, 8'h00, 16'h00FF, 16'h1111, 16'h0000, 16'hFF00};
    vecs[3] = '{4'hF,    3'd6, 3'd1, 3'd2, 8'h33, 16'h1234, 16'h5678, 16'h5678, 16'h0000};
    vecs[4] = '{OP_ANDI, 3'd7, 3'd2, 3'd3, 8'h0F, 16'hABCD, 16'h0000, 16'h000F, 16'h000D};
    vecs[5] = '{OP_SUB,  3'd0, 3'd1, 3'd2, 8'h00, 16'h0005, 16'h0007, 16'h0007, 16'hFFFE};
    vecs[6] = '{OP_ADD,  3'd1, 3'd1, 3'd1, 8'h00, 16'h0003, 16'h0003, 16'h0003, 16'h0006};

    fork
      monitor();
    join_none

    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      preload(vecs[i].rs1, vecs[i].v1);
      preload(vecs[i].rs2, vecs[i].v2);
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0);
      wait_done();
      chk($sformatf("vec%0d_alu_in2", i), last_in2, vecs[i].exp_in2);
      chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
      if (i == 0) chk("vec0_retired", retired_count, 16'd1);
    end

    // Reset during EXEC: no writeback, everything back to zero.
    base_wb = wb_total;
    issue(OP_ADD, 3'd2, 3'd3, 3'd4, 8'h00, 1'b0);
    for (int n = 0; n < 10 && !alu_enable; n++) step();
    if (!alu_enable) fail("midop_exec_timeout");
    reset_n = 1'b0;
    #1;
    check_all_zero("midop");
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("midop_ready_after", {15'd0, instr_ready}, 16'd1);
    chk("midop_retired_after", retired_count, 16'd0);
    chk("midop_no_wb", 16'(wb_total - base_wb), 16'd0);

    // Back-to-back with instr_valid held high.
    wb_cyc.delete();
    base_ret = exp_retired;
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00, 1'b1);
    issue(OP_XOR, 3'd2, 3'd1, 3'd3, 8'h00, 1'b1);
    issue(OP_ADDI, 3'd3, 3'd2, 3'd0, 8'h81, 1'b0);
    wait_done();
    chk("b2b_wb_count", 16'(wb_cyc.size()), 16'd3);
    if (wb_cyc.size() == 3) begin
      chk("b2b_spacing1", 16'(wb_cyc[1] - wb_cyc[0]), 16'd4);
      chk("b2b_spacing2", 16'(wb_cyc[2] - wb_cyc[1]), 16'd4);
    end
    chk("b2b_retired", retired_count, base_ret + 16'd3);

    // Wrap of retired_count.
    force dut.retired_count = 16'hFFFF;
    exp_retired = 16'hFFFF;
    step();
    release dut.retired_count;
    step();
    chk("wrap_preload", retired_count, 16'hFFFF);
    issue(OP_OR, 3'd4, 3'd5, 3'd6, 8'h00, 1'b0);
    wait_done();
    chk("wrap_retired", retired_count, 16'h0000);

    // Randomized instructions against the reference model.
    for (int r = 0; r < 8; r++) preload(3'(r), 16'($urandom));
    for (int k = 0; k < 60; k++) begin
      hold = ($urandom_range(0, 3) == 0);
      issue(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 2)) step();
    end
    instr_valid = 1'b0;
    wait_done();
    for (int r = 0; r < 8; r++) chk($sformatf("final_r%0d", r), rf[r], ref_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
